dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory subsystem that sits directly downstream of the pipelined RV32I core's memory stage. It consumes the core's data address, write data, write strobe and byte enables, and returns registered read data to the core's writeback capture. It contains a byte-writable synchronous data RAM and a small memory-mapped register block:
- 8-bit GPIO output port
- synchronised 8-bit GPIO input
- free-running 32-bit timer with compare interrupt

## Interface
Parameters:
- DMEM_BASE, 32'h1000_2000, byte base address of data RAM (aligned to RAM size)
- DMEM_WORDS, 2048, RAM depth in 32-bit words (power of two)
- MMIO_BASE, 32'hFFFF_0000, byte base of 64-byte register window

Ports:
- clk  in  1  clock; all state updates on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- MemWriteM  in  1  write strobe from memory stage
- ALUResult  in  32  byte address of current access
- WriteData  in  32  lane-aligned store data
- Byte_Enable  in  4  bit i enables lane i = bits [8i+7:8i]
- ReadData  out  32  registered read data to core
- gpio_in  in  8  asynchronous external inputs
- gpio_out  out  8  GPIO output register
- timer_irq  out  1  timer interrupt level

## Operation
Address decode (ALUResult[1:0] ignored; word granular):
- RAM hit: DMEM_BASE <= addr < DMEM_BASE + 4*DMEM_WORDS; word index = addr[log2(DMEM_WORDS)+1:2].
- MMIO hit: addr[31:6] == MMIO_BASE[31:6]; register offset = addr[5:2].
- Otherwise unmapped: reads return 0, writes ignored.

Writes (MemWriteM=1): only lanes with Byte_Enable bit set change. This applies to RAM and all RW registers. Byte_Enable=0000 with MemWriteM=1 changes nothing.

Reads: a read occurs every cycle (the core has no read strobe). Reads have no side effects.

MMIO registers (word offsets):
- 0x00 GPIO_OUT: RW. Bits [7:0] drive gpio_out; bits [31:8] read 0.
- 0x04 GPIO_IN: RO. Two-flop synchroniser on gpio_in; bits [31:8] read 0.
- 0x08 MTIME: RW. Increments by 1 every cycle and wraps FFFF_FFFF -> 0. A write loads the written lanes, and the increment is suppressed that cycle; the write wins.
- 0x0C MTIMECMP: RW.
- 0x10 TCTRL:
  - bit0 IE (RW).
  - bit1 PEND (write-1-to-clear).
  - Other bits read 0.
- Offsets 0x14 to 0x3C read 0; writes ignored.

Interrupt:
- PEND sets on any cycle where the registered MTIME == MTIMECMP, regardless of IE.
- If a set and a W1C occur in the same cycle, set wins.
- timer_irq = IE & PEND, driven from flops with no combinational path from inputs.

## Timing
- Read latency is 1 cycle. Address presented in cycle N gives ReadData valid after edge N+1, held until the next edge.
- Read-during-write to the same word returns the old (pre-write) data, for RAM and MMIO.
- A write issued at edge N is visible to a read presented in cycle N+1, seen on ReadData after edge N+2.
- Reset values (asserted asynchronously):
  - ReadData=0, gpio_out=0
  - MTIME=0, MTIMECMP=FFFF_FFFF
  - TCTRL=0, timer_irq=0
  - synchroniser flops=0
- RAM contents are not reset. Simulation initialises RAM to 0.
- Reset asserted mid-access aborts the access: no RAM write at the edge where n_rst=0. The first edge after deassert behaves as a normal cycle.
- GPIO_IN reflects a gpio_in change 2 edges after it is sampled. The read adds 1 more cycle.
- Match timing: if MTIME==MTIMECMP is registered after edge N, PEND is 1 after edge N+1, and timer_irq likewise.

## Test plan
- Reset: hold n_rst=0 mid-run for 3 cycles -> ReadData=0, gpio_out=00, timer_irq=0. Reading MTIMECMP after reset returns FFFF_FFFF.
- Byte writes: write 0x1122_3344 to 0x1000_2010 with BE=1111, then 0xAA00_0000 with BE=1000 -> read returns 0xAA22_3344 one cycle after address. Read-during-write returns the old word.
- Decode boundaries:
  - 0x1000_3FFC is RAM (last word).
  - 0x1000_4000 and 0x1000_1FFC read 0 and writes have no effect.
  - MMIO offset 0x20 reads 0.
- GPIO: write 0x0000_00A5 to 0xFFFF_0000 -> gpio_out=A5 after the edge. Drive gpio_in=3C -> GPIO_IN read returns 0x3C, 3 cycles after the change.
- Timer:
  - Write MTIMECMP=0x20, MTIME=0x10, TCTRL=1 -> timer_irq rises 1 cycle after MTIME reads 0x20.
  - Write TCTRL=3 in the match cycle -> PEND stays 1.
  - Write TCTRL=3 later -> timer_irq=0.
- Wrap and write priority: load MTIME=FFFF_FFFE -> reads FFFF_FFFF then 0000_0000. A write of 5 in the same cycle as the increment -> MTIME=5, then 6.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory for the RV32I core: byte-writable synchronous RAM plus a small
// MMIO block (GPIO out/in, free-running timer with compare interrupt), 1-cycle reads.
module dmem_mmio #(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_2000,
    parameter int unsigned DMEM_WORDS = 2048,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  Byte_Enable,
    output logic [31:0] ReadData,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int IDX_W = $clog2(DMEM_WORDS);

    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_MTIME    = 4'd2;
    localparam logic [3:0] OFF_MTIMECMP = 4'd3;
    localparam logic [3:0] OFF_TCTRL    = 4'd4;

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  laneEn);
        logic [31:0] merged;
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) merged[8*i +: 8] = newWord[8*i +: 8];
        end
        return merged;
    endfunction

    logic             ramHit;
    logic             mmioHit;
    logic [IDX_W-1:0] ramIdx;
    logic [3:0]       regOff;
    logic             unusedAddrBits;

    // RAM is size-aligned, so a hit is just a match of the bits above the index
    assign ramHit         = (ALUResult[31:IDX_W+2] == DMEM_BASE[31:IDX_W+2]);
    assign ramIdx         = ALUResult[IDX_W+1:2];
    assign mmioHit        = (ALUResult[31:6] == MMIO_BASE[31:6]);
    assign regOff         = ALUResult[5:2];
    assign unusedAddrBits = ^ALUResult[1:0];

    logic regWr;
    logic wrGpioOut;
    logic wrMtime;
    logic wrMtimecmp;
    logic wrTctrl;

    assign regWr      = MemWriteM & mmioHit;
    assign wrGpioOut  = regWr & (regOff == OFF_GPIO_OUT);
    assign wrMtime    = regWr & (regOff == OFF_MTIME);
    assign wrMtimecmp = regWr & (regOff == OFF_MTIMECMP);
    assign wrTctrl    = regWr & (regOff == OFF_TCTRL);

    logic [31:0] ramArray [DMEM_WORDS];
    logic [31:0] ramQ_p0;

    // Stage p0: RAM write and registered read; writes are blocked while in reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ramQ_p0 <= '0;
        end else begin
            if (MemWriteM && ramHit) begin
                for (int i = 0; i < 4; i++) begin
                    if (Byte_Enable[i]) ramArray[ramIdx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
            ramQ_p0 <= ramArray[ramIdx];
        end
    end

    logic [7:0]  gpioOutReg;
    logic [7:0]  gpioMeta;
    logic [7:0]  gpioSync;
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic        ie;
    logic        pend;
    logic        pendSet;
    logic        pendClr;
    logic [31:0] gpioMerged;

    assign gpioMerged = mergeLanes({24'd0, gpioOutReg}, WriteData, Byte_Enable);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gpioOutReg <= '0;
        end else if (wrGpioOut) begin
            gpioOutReg <= gpioMerged[7:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gpioMeta <= '0;
            gpioSync <= '0;
        end else begin
            gpioMeta <= gpio_in;
            gpioSync <= gpioMeta;
        end
    end

    // A write to MTIME replaces the increment for that cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mtime <= '0;
        end else if (wrMtime) begin
            mtime <= mergeLanes(mtime, WriteData, Byte_Enable);
        end else begin
            mtime <= mtime + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mtimecmp <= '1;
        end else if (wrMtimecmp) begin
            mtimecmp <= mergeLanes(mtimecmp, WriteData, Byte_Enable);
        end
    end

    assign pendSet = (mtime == mtimecmp);
    assign pendClr = wrTctrl & Byte_Enable[0] & WriteData[1];

    // A match in the same cycle as a W1C keeps PEND set
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ie   <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (wrTctrl && Byte_Enable[0]) ie <= WriteData[0];
            pend <= pendSet | (pend & ~pendClr);
        end
    end

    logic [31:0] mmioRd;

    always_comb begin
        mmioRd = '0;
        if (mmioHit) begin
            case (regOff)
                OFF_GPIO_OUT: mmioRd = {24'd0, gpioOutReg};
                OFF_GPIO_IN:  mmioRd = {24'd0, gpioSync};
                OFF_MTIME:    mmioRd = mtime;
                OFF_MTIMECMP: mmioRd = mtimecmp;
                OFF_TCTRL:    mmioRd = {30'd0, pend, ie};
                default:      mmioRd = '0;
            endcase
        end
    end

    logic        rdSel_p0;
    logic [31:0] mmioQ_p0;

    // Stage p0: register read source and MMIO/unmapped read value
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdSel_p0 <= 1'b0;
            mmioQ_p0 <= '0;
        end else begin
            rdSel_p0 <= ramHit;
            mmioQ_p0 <= mmioRd;
        end
    end

    assign ReadData  = rdSel_p0 ? ramQ_p0 : mmioQ_p0;
    assign gpio_out  = gpioOutReg;
    assign timer_irq = ie & pend;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_dmem_mmio;

    localparam logic [31:0] DMEM_BASE = 32'h1000_2000;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_GPO  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPI  = 32'hFFFF_0004;
    localparam logic [31:0] A_TIME = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        MemWriteM;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [3:0]  Byte_Enable;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    always #5 clk = ~clk;

    dmem_mmio dut (
        .clk(clk), .n_rst(n_rst), .MemWriteM(MemWriteM), .ALUResult(ALUResult),
        .WriteData(WriteData), .Byte_Enable(Byte_Enable), .ReadData(ReadData),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] mMem [int];
    logic [7:0]  mGpioOut, mSync1, mSync2;
    logic [31:0] mTime, mCmp;
    logic        mIe, mPend;

    function automatic logic [31:0] laneMerge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic bit isRam(input logic [31:0] a);
        return (longint'(a) >= longint'(DMEM_BASE)) && (longint'(a) < longint'(DMEM_BASE) + 4 * 2048);
    endfunction

    function automatic bit isMmio(input logic [31:0] a);
        return (a & 32'hFFFF_FFC0) == MMIO_BASE;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        int idx;
        if (isRam(a)) begin
            idx = int'((a - DMEM_BASE) >> 2);
            return mMem.exists(idx) ? mMem[idx] : 32'd0;
        end
        if (isMmio(a)) begin
            case ((a - MMIO_BASE) >> 2)
                0: return {24'd0, mGpioOut};
                1: return {24'd0, mSync2};
                2: return mTime;
                3: return mCmp;
                4: return {30'd0, mPend, mIe};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic modelReset();
        mGpioOut = '0; mSync1 = '0; mSync2 = '0;
        mTime = '0; mCmp = '1; mIe = 1'b0; mPend = 1'b0;
    endtask

    // One clock: predict from current inputs, advance through the edge, compare
    task automatic step();
        logic [31:0] expRd, nTime, nCmp, tmp;
        logic [7:0]  nGpio;
        logic        nIe, clr;
        int          idx;
        expRd = modelRead(ALUResult);
        nGpio = mGpioOut; nCmp = mCmp; nIe = mIe; clr = 1'b0;
        nTime = mTime + 32'd1;
        if (MemWriteM && isRam(ALUResult)) begin
            idx = int'((ALUResult - DMEM_BASE) >> 2);
            mMem[idx] = laneMerge(expRd, WriteData, Byte_Enable);
        end
        if (MemWriteM && isMmio(ALUResult)) begin
            case ((ALUResult - MMIO_BASE) >> 2)
                0: begin tmp = laneMerge({24'd0, mGpioOut}, WriteData, Byte_Enable); nGpio = tmp[7:0]; end
                2: nTime = laneMerge(mTime, WriteData, Byte_Enable);
                3: nCmp = laneMerge(mCmp, WriteData, Byte_Enable);
                4: if (Byte_Enable[0]) begin nIe = WriteData[0]; clr = WriteData[1]; end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        mPend = (mTime == mCmp) || (mPend && !clr);
        mSync2 = mSync1; mSync1 = gpio_in;
        mGpioOut = nGpio; mTime = nTime; mCmp = nCmp; mIe = nIe;
        checkVal("rdata", ReadData, expRd);
        checkVal("gpio_out", {24'd0, gpio_out}, {24'd0, mGpioOut});
        checkVal("timer_irq", {31'd0, timer_irq}, {31'd0, mIe & mPend});
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        MemWriteM = we; ALUResult = a; WriteData = wd; Byte_Enable = be;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        access(1'b1, a, wd, be);
    endtask

    task automatic rd(input logic [31:0] a);
        access(1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic applyReset(input int n);
        n_rst = 1'b0; #1;
        modelReset();
        checkVal("rst_rdata", ReadData, 32'd0);
        checkVal("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        checkVal("rst_irq", {31'd0, timer_irq}, 32'd0);
        repeat (n) begin
            @(posedge clk); #1;
            checkVal("rst_hold_rdata", ReadData, 32'd0);
        end
        n_rst = 1'b1;
    endtask

    logic [31:0] unmapped [5] = '{32'h1000_4000, 32'h1000_1FFC, 32'h0000_0000,
                                  32'hFFFF_0040, 32'h7FFF_0000};

    initial begin
        bit   found;
        logic prevIrq;
        logic [31:0] a;
        n_rst = 1'b0; MemWriteM = 1'b0; ALUResult = '0; WriteData = '0;
        Byte_Enable = '0; gpio_in = '0;
        @(posedge clk); #1;
        applyReset(3);

        rd(A_CMP);
        checkVal("cmp_reset", ReadData, 32'hFFFF_FFFF);

        for (int i = 0; i < 16; i++) wr(DMEM_BASE + 32'(4 * i), 32'd0, 4'hF);
        wr(32'h1000_3FFC, 32'd0, 4'hF);

        wr(32'h1000_2010, 32'h1122_3344, 4'hF);
        wr(32'h1000_2010, 32'hAA00_0000, 4'h8);
        checkVal("rdw_old", ReadData, 32'h1122_3344);
        rd(32'h1000_2010);
        checkVal("byte_merge", ReadData, 32'hAA22_3344);
        wr(32'h1000_2010, 32'hFFFF_FFFF, 4'h0);
        rd(32'h1000_2010);
        checkVal("be_zero", ReadData, 32'hAA22_3344);

        wr(32'h1000_3FFC, 32'h1234_5678, 4'hF);
        rd(32'h1000_3FFC);
        checkVal("last_word", ReadData, 32'h1234_5678);
        wr(32'h1000_4000, 32'hDEAD_BEEF, 4'hF);
        rd(32'h1000_4000);
        checkVal("above_ram", ReadData, 32'd0);
        wr(32'h1000_1FFC, 32'hCAFE_F00D, 4'hF);
        rd(32'h1000_1FFC);
        checkVal("below_ram", ReadData, 32'd0);
        rd(32'h1000_2000);
        checkVal("no_alias_lo", ReadData, 32'd0);
        rd(32'h1000_3FFC);
        checkVal("no_alias_hi", ReadData, 32'h1234_5678);
        wr(32'hFFFF_0020, 32'h5555_AAAA, 4'hF);
        rd(32'hFFFF_0020);
        checkVal("mmio_hole", ReadData, 32'd0);

        wr(A_GPO, 32'h0000_00A5, 4'hF);
        checkVal("gpio_out_a5", {24'd0, gpio_out}, 32'h0000_00A5);
        gpio_in = 8'h3C;
        rd(A_GPI);
        rd(A_GPI);
        checkVal("gpio_in_early", ReadData, 32'd0);
        rd(A_GPI);
        checkVal("gpio_in_3c", ReadData, 32'h0000_003C);

        wr(A_CMP, 32'h20, 4'hF);
        wr(A_TIME, 32'h10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        found = 1'b0;
        prevIrq = timer_irq;
        for (int i = 0; i < 40 && !found; i++) begin
            rd(A_TIME);
            if (ReadData == 32'h20) begin
                found = 1'b1;
                checkVal("irq_before_match", {31'd0, prevIrq}, 32'd0);
                checkVal("irq_at_match", {31'd0, timer_irq}, 32'd1);
            end
            prevIrq = timer_irq;
        end
        checkVal("match_seen", {31'd0, found}, 32'd1);

        wr(A_TIME, 32'h1D, 4'hF);
        wr(A_CTRL, 32'h3, 4'hF);
        rd(A_CTRL);
        rd(A_CTRL);
        checkVal("pre_match_irq", {31'd0, timer_irq}, 32'd0);
        wr(A_CTRL, 32'h3, 4'hF);
        checkVal("set_wins", {31'd0, timer_irq}, 32'd1);
        rd(A_TIME);
        rd(A_TIME);
        wr(A_CTRL, 32'h3, 4'hF);
        checkVal("w1c_clear", {31'd0, timer_irq}, 32'd0);

        wr(A_TIME, 32'hFFFF_FFFE, 4'hF);
        rd(A_TIME);
        checkVal("wrap_fe", ReadData, 32'hFFFF_FFFE);
        rd(A_TIME);
        checkVal("wrap_ff", ReadData, 32'hFFFF_FFFF);
        rd(A_TIME);
        checkVal("wrap_00", ReadData, 32'h0000_0000);
        wr(A_TIME, 32'h5, 4'hF);
        rd(A_TIME);
        checkVal("wprio_5", ReadData, 32'h5);
        rd(A_TIME);
        checkVal("wprio_6", ReadData, 32'h6);

        MemWriteM = 1'b1; ALUResult = 32'h1000_2000; WriteData = 32'hFFFF_FFFF; Byte_Enable = 4'hF;
        applyReset(3);
        rd(32'h1000_2000);
        checkVal("rst_no_write", ReadData, 32'd0);
        rd(A_CMP);
        checkVal("cmp_after_rst", ReadData, 32'hFFFF_FFFF);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 5) begin
                if ($urandom_range(0, 16) == 16) a = 32'h1000_3FFC;
                else a = DMEM_BASE + 32'(4 * $urandom_range(0, 15));
                a = a | 32'($urandom_range(0, 3));
            end else if (sel < 8) begin
                a = MMIO_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end else begin
                a = unmapped[$urandom_range(0, 4)];
            end
            access(1'($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
